// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR output decimator slice.
// Optional feature macro used by the top: DECIM_DROP_COUNT_EN.
package fir_pkg;

    localparam int DATA_W     = 8;
    localparam int MAX_DEC    = 8;
    localparam int ACC_W      = DATA_W + 3;
    localparam int FIFO_DEPTH = 4;

    localparam int PHASE_W = $clog2(MAX_DEC);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

    typedef logic [DATA_W-1:0]  sample_t;
    typedef logic [ACC_W-1:0]   acc_t;
    typedef logic [PHASE_W-1:0] phase_t;
    typedef logic [PHASE_W:0]   factor_t;

endpackage

// File: rtl/dec_out_fifo.sv
// Synchronous first-word-fall-through FIFO; head is read straight from the
// register array, so a pushed word appears the cycle after the push.
module dec_out_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic [WIDTH-1:0]             o_head
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int LEVEL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LEVEL_W'(DEPTH));
    assign o_level = r_level;
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pop is resolved first, so a push into a full FIFO succeeds when the head leaves.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: storage is deliberately not reset; o_head is masked while empty,
    // so stale entries are never observable and the array stays plain flops.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + LEVEL_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_level <= r_level - LEVEL_W'(1);
            end
        end
    end

endmodule

// File: rtl/fir_out_decimator.sv
// Accumulate-and-dump decimator (factor 1..8) feeding a 4-entry FWFT FIFO.
// Define DECIM_DROP_COUNT_EN to build the saturating dropped-dump counter.
module fir_out_decimator
    import fir_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         dec_sel,
    input  logic               in_valid,
    input  sample_t            in_data,
    output logic               out_valid,
    output acc_t               out_data,
    input  logic               out_ready,
    output logic [LEVEL_W-1:0] level,
    output logic               overflow,
    output logic [7:0]         drop_count
);

    phase_t  r_phase;
    acc_t    r_acc;
    factor_t r_factor;
    logic    r_overflow;

    factor_t w_factor;
    acc_t    w_sum;
    logic    w_dump;
    logic    w_full;
    logic    w_empty;
    logic    w_drop;

    // A frame latches its factor on its first sample and uses it immediately.
    assign w_factor = (r_phase == '0) ? ({1'b0, dec_sel} + factor_t'(1)) : r_factor;
    assign w_sum    = (r_phase == '0) ? acc_t'(in_data) : (r_acc + acc_t'(in_data));
    assign w_dump   = in_valid && ({1'b0, r_phase} == (w_factor - factor_t'(1)));
    assign w_drop   = w_dump && w_full && !(out_valid && out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= '0;
            r_acc      <= '0;
            r_factor   <= factor_t'(1);
            r_overflow <= 1'b0;
        end else begin
            if (in_valid) begin
                r_acc    <= w_sum;
                r_factor <= w_factor;
                r_phase  <= w_dump ? '0 : (r_phase + phase_t'(1));
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    dec_out_fifo #(
        .WIDTH (ACC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_dump),
        .i_data  (w_sum),
        .i_pop   (out_ready),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level),
        .o_head  (out_data)
    );

    assign out_valid = !w_empty;
    assign overflow  = r_overflow;

`ifdef DECIM_DROP_COUNT_EN
    logic [7:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = '0;
`endif

endmodule

// File: doc/fir_out_decimator.md
Name: fir_out_decimator

Overview:
- Sits directly downstream of the 8-tap FIR pipeline; consumes its 8-bit output stream, one sample per clk when in_valid is high.
- Performs accumulate-and-dump decimation by a runtime factor 1..8 and emits full-precision sums.
- Buffers sums in a small output FIFO with a valid/ready handshake.
- The FIR cannot stall, so the input side has no back-pressure; a word that cannot be queued is dropped and flagged.

Parameters:
- DATA_W, 8, input sample width (FIR output width).
- MAX_DEC, 8, maximum decimation factor.
- ACC_W, DATA_W+3, accumulator and output width; 8*255=2040 fits, so no overflow is possible.
- FIFO_DEPTH, 4, output FIFO entries (power of two).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high; single clock domain.
- dec_sel  in  3  decimation factor minus 1 (0 means factor 1, 7 means factor 8).
- in_valid  in  1  in_data is a valid FIR output this cycle.
- in_data  in  DATA_W  FIR output sample, unsigned.
- out_valid  out  1  FIFO head is valid.
- out_data  out  ACC_W  FIFO head (decimated sum).
- out_ready  in  1  consumer accepts the head this cycle.
- level  out  3  FIFO occupancy, 0..4.
- overflow  out  1  sticky: at least one dump was dropped.
- drop_count  out  8  dropped-dump counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at a posedge): phase=0, acc=0, factor_q=1, FIFO emptied, out_valid=0, out_data=0, level=0, overflow=0, drop_count=0.
  - Reset mid-frame discards the partial sum and all queued words.
- Input acceptance:
  - Every in_valid=1 cycle is accepted unconditionally; in_valid=0 cycles do not advance phase.
- Phase counter and factor latch:
  - phase counts accepted samples, 0..factor_q-1.
  - When a sample is accepted with phase==0, factor_q <= dec_sel+1, and that new factor applies to the current frame.
  - dec_sel changes at any other phase are ignored until the next frame starts.
- Accumulator:
  - At phase 0: acc <= in_data.
  - Otherwise: acc <= acc + in_data.
  - Zero-extended unsigned arithmetic, width ACC_W.
- Dump:
  - On the accepted sample where phase==factor_q-1, using the factor latched for this frame, the dump word acc+in_data is pushed to the FIFO (in_data alone when factor is 1).
  - phase then returns to 0.
  - Latency: the word is visible on out_data/out_valid the cycle after the last contributing sample is accepted.
- FIFO:
  - First-word-fall-through, registered.
  - Pop occurs when out_valid && out_ready.
  - Pop and push in the same cycle:
    - When full: pop is evaluated first and the push is accepted; level stays 4.
    - When empty: the push lands and out_valid=1 next cycle; the word does not bypass in the same cycle.
  - Push when full without a pop: the word is dropped, overflow <= 1 (sticky until rst), FIFO contents unchanged.
  - out_ready while empty has no effect.
- level tracks occupancy exactly: +1 on push, -1 on pop, unchanged on simultaneous push and pop or on a drop.

Optional Feature:
- Macro: DECIM_DROP_COUNT_EN.
- Defined: drop_count increments on every dropped dump, saturates at 255, and clears only on rst.
- Undefined: drop_count is tied to 0 and no counter logic is generated; overflow behaviour is unchanged.

Decomposition:
- Shared package fir_pkg holds:
  - DATA_W, ACC_W, MAX_DEC, FIFO_DEPTH constants;
  - typedefs sample_t (DATA_W) and acc_t (ACC_W).
- One sub-module, dec_out_fifo: synchronous FWFT FIFO with push, pop, full, empty, level, parameterised on width and depth.
- Phase, accumulator and drop logic stay in fir_out_decimator.

Test Plan:
1. Factor 1: dec_sel=0, out_ready=1, in_valid held high, in_data=1,0,1,0 -> out_data 1,0,1,0, each one cycle after its input; level never exceeds 1.
2. Factor 4: dec_sel=3, out_ready=1, in_data=1,2,3,4,255,255,255,255 -> outputs 10 then 1020; in_valid gaps inserted mid-frame -> same results.
3. Mid-frame factor change: dec_sel=3 at frame start, switched to 1 after 2 samples -> first frame still sums 4 samples; the next frame sums 2.
4. Full and overflow: out_ready=0, factor 1, 6 samples 1..6 -> level=4 holding 1,2,3,4; samples 5 and 6 dropped; overflow=1; drop_count=2 with the macro defined, 0 without.
5. Simultaneous push and pop at full: level=4, out_ready=1 on the same cycle as a dump -> level stays 4, no drop, order preserved.
6. Reset mid-frame: factor 4 with 2 samples (5,6) accumulated, pulse rst -> all outputs 0; next 4 samples of 1 -> output 4, not 15.
